// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a word-addressed data memory.
// Define MAU_RMW_EN to build read-modify-write support for sub-word stores.
module mem_access_unit #(
    parameter int DEPTH = 128
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadData,
    output logic [31:0] Address,
    output logic        WE,
    output logic [31:0] WD,
    input  logic [31:0] ReadData
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_addr;
    logic [1:0]     r_size;
    logic [1:0]     r_lane;
    logic           r_sext;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic           r_we;
    logic [31:0]    r_wd;
    logic [31:0]    r_load;
`ifdef MAU_RMW_EN
    logic           r_wr;
    logic [15:0]    r_sdata;
`endif
    logic           w_err;

    // Lane selection and extension of a fetched word for loads
    function automatic logic [31:0] f_load(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  lane,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   f_load = {{24{sx & b[7]}}, b};
            2'b01:   f_load = {{16{sx & h[15]}}, h};
            default: f_load = w;
        endcase
    endfunction

`ifdef MAU_RMW_EN
    // Replace the addressed byte or halfword lane of the fetched word
    function automatic logic [31:0] f_merge(
        input logic [31:0] w,
        input logic [15:0] sd,
        input logic [1:0]  sz,
        input logic [1:0]  lane
    );
        f_merge = w;
        if (sz == 2'b00)
            f_merge[{lane, 3'b000} +: 8] = sd[7:0];
        else if (lane[1])
            f_merge[31:16] = sd;
        else
            f_merge[15:0] = sd;
    endfunction
`endif

    // Classify an incoming request as illegal
    always_comb begin
        w_err = (Size == 2'b11)
              | ((Size == 2'b01) & Addr[0])
              | ((Size == 2'b10) & (|Addr[1:0]))
              | (|Addr[31:AW+2]);
`ifndef MAU_RMW_EN
        w_err = w_err | (MemWrite & (Size != 2'b10));
`endif
    end

    // Request sequencer with registered memory and handshake outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_lane  <= 2'b00;
            r_sext  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_wd    <= '0;
            r_load  <= '0;
`ifdef MAU_RMW_EN
            r_wr    <= 1'b0;
            r_sdata <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_addr <= Addr[AW+1:2];
                        r_size <= Size;
                        r_lane <= Addr[1:0];
                        r_sext <= SignExt;
                        r_busy <= 1'b1;
`ifdef MAU_RMW_EN
                        r_wr    <= MemWrite;
                        r_sdata <= StoreData[15:0];
`endif
                        if (w_err) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (MemWrite && Size == 2'b10) begin
                            r_state <= S_WRITE;
                            r_we    <= 1'b1;
                            r_wd    <= StoreData;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
`ifdef MAU_RMW_EN
                    if (r_wr) begin
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_wd    <= f_merge(ReadData, r_sdata,
                                           r_size, r_lane);
                    end else
`endif
                    begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_load  <= f_load(ReadData, r_size,
                                          r_lane, r_sext);
                    end
                end
                S_WRITE: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Err      = r_err;
    assign LoadData = r_load;
    assign Address  = {{(32-AW){1'b0}}, r_addr};
    assign WE       = r_we;
    assign WD       = r_wd;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random requests against a memory model.
// Builds for both MAU_RMW_EN defined and undefined.
module tb_mem_access_unit;
    localparam int DEPTH = 128;
    localparam int AW = 7;
`ifdef MAU_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        Start;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [31:0] LoadData;
    logic [31:0] Address;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] ReadData;

    logic [31:0] tb_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int n_assert = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .Start(Start),
        .MemWrite(MemWrite), .Size(Size), .SignExt(SignExt),
        .Addr(Addr), .StoreData(StoreData), .Busy(Busy),
        .Done(Done), .Err(Err), .LoadData(LoadData),
        .Address(Address), .WE(WE), .WD(WD), .ReadData(ReadData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ReadData = tb_mem[Address[AW-1:0]];

    always @(posedge CLK) begin
        if (WE) begin
            tb_mem[Address[AW-1:0]] <= WD;
            we_cnt++;
        end
        if (Done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input bit wr, input int sz,
                                 input logic [31:0] a);
        if (sz == 3) return 1;
        if (sz == 1 && a % 2 != 0) return 1;
        if (sz == 2 && a % 4 != 0) return 1;
        if (a >= 4 * DEPTH) return 1;
        if (!RMW && wr && sz != 2) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input bit sx,
                                           input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        w = ref_mem[a / 4];
        if (sz == 2) return w;
        if (sz == 0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sx && v >= 128) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sx && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input int sz,
                                            input logic [31:0] a,
                                            input logic [31:0] sd);
        logic [31:0] w;
        logic [31:0] mask;
        int sh;
        w = ref_mem[a / 4];
        if (sz == 2) return sd;
        sh = (sz == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((sd << sh) & mask);
    endfunction

    task automatic do_req(input bit wr, input int sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] sd);
        bit e;
        int lat_exp;
        int lat;
        int we0;
        int diffs;
        logic [31:0] ld_exp;
        e = m_err(wr, sz, a);
        ld_exp = 0;
        if (e) lat_exp = 1;
        else if (!wr || sz == 2) lat_exp = 2;
        else lat_exp = 3;
        if (!e && !wr) ld_exp = m_load(sz, sx, a);
        if (!e && wr) ref_mem[a / 4] = m_store(sz, a, sd);
        @(negedge CLK);
        Start = 1'b1;
        MemWrite = wr;
        Size = 2'(sz);
        SignExt = sx;
        Addr = a;
        StoreData = sd;
        we0 = we_cnt;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        MemWrite = 1'($urandom);
        Size = 2'($urandom);
        SignExt = 1'($urandom);
        Addr = $urandom;
        StoreData = $urandom;
        chk("busy_after_accept", 32'(Busy), 32'd1);
        lat = 1;
        while (Done !== 1'b1 && lat < 8) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("done_latency", lat, lat_exp);
        chk("err", 32'(Err), 32'(e));
        if (!e && !wr) chk("load_data", LoadData, ld_exp);
        @(posedge CLK);
        #1;
        chk("done_single", 32'(Done), 32'd0);
        chk("idle_busy", 32'(Busy), 32'd0);
        chk("we_cycles", we_cnt - we0, (!e && wr) ? 1 : 0);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (tb_mem[i] !== ref_mem[i]) diffs++;
        chk("mem_words_differing", diffs, 0);
    endtask

    initial begin
        int d0;
        int w0;
        logic [31:0] ra;
        RESET_N = 1'b0;
        Start = 1'b0;
        MemWrite = 1'b0;
        Size = 2'b00;
        SignExt = 1'b0;
        Addr = '0;
        StoreData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i] = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[0] = 32'h0; tb_mem[1] = 32'h2; tb_mem[2] = 32'hFFFF_FFFE;
        ref_mem[0] = 32'h0; ref_mem[1] = 32'h2; ref_mem[2] = 32'hFFFF_FFFE;
        #12;
        chk("rst_address", Address, 32'h0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_wd", WD, 32'h0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_loaddata", LoadData, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        do_req(1'b0, 0, 1'b1, 32'h8, 32'h0);
        chk("plan_lb_signed", LoadData, 32'hFFFF_FFFE);
        do_req(1'b0, 0, 1'b0, 32'hB, 32'h0);
        chk("plan_lbu", LoadData, 32'h0000_00FF);
        do_req(1'b1, 1, 1'b0, 32'h6, 32'h1234_ABCD);
        do_req(1'b0, 2, 1'b0, 32'h4, 32'h0);
`ifdef MAU_RMW_EN
        chk("plan_sh_readback", LoadData, 32'hABCD_0002);
`else
        chk("plan_sh_readback", LoadData, 32'h0000_0002);
`endif
        do_req(1'b1, 2, 1'b0, 32'h5, 32'h5555_5555);
        do_req(1'b1, 2, 1'b0, 32'h200, 32'h6666_6666);
        do_req(1'b1, 0, 1'b0, 32'h0, 32'h0000_00A5);
        do_req(1'b1, 2, 1'b0, 32'h0, 32'hDEAD_BEEF);
        do_req(1'b0, 2, 1'b0, 32'h0, 32'h0);
        chk("plan_sw_readback", LoadData, 32'hDEAD_BEEF);

        // Abort a store while it sits in WRITE
        d0 = done_cnt;
        w0 = we_cnt;
        @(negedge CLK);
        Start = 1'b1;
        MemWrite = 1'b1;
        SignExt = 1'b0;
        StoreData = 32'h7777_9999;
`ifdef MAU_RMW_EN
        Size = 2'b01;
        Addr = 32'h6;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        @(posedge CLK);
`else
        Size = 2'b10;
        Addr = 32'h4;
        @(posedge CLK);
`endif
        #1;
        Start = 1'b0;
        chk("abort_we_before", 32'(WE), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("abort_we_low", 32'(WE), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        chk("abort_word", tb_mem[1], ref_mem[1]);
        chk("abort_we_cnt", we_cnt - w0, 0);
        chk("abort_done_cnt", done_cnt - d0, 0);

        // Start held high through a whole load
        @(negedge CLK);
        Start = 1'b1;
        MemWrite = 1'b0;
        Size = 2'b10;
        Addr = 32'h8;
        @(posedge CLK);
        #1;
        chk("b2b_busy_e0", 32'(Busy), 32'd1);
        @(posedge CLK);
        #1;
        chk("b2b_done_e1", 32'(Done), 32'd1);
        chk("b2b_load", LoadData, ref_mem[2]);
        @(posedge CLK);
        #1;
        chk("b2b_idle_e2", 32'(Busy), 32'd0);
        @(posedge CLK);
        #1;
        chk("b2b_reaccept_e3", 32'(Busy), 32'd1);
        Start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("b2b_settled", 32'(Busy), 32'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = 32'($urandom_range(0, 4 * DEPTH - 1));
            do_req(1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), ra, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
